// File: rtl/instruction_fetch_arbiter_pkg.sv
// Shared defaults and the pointer-width helper for the instruction fetch arbiter.
package instruction_fetch_arbiter_pkg;
  localparam int unsigned NUM_CORES_DEF     = 4;
  localparam int unsigned ADDR_WIDTH_IM_DEF = 8;
  localparam int unsigned INSTR_WIDTH_DEF   = 32;

  // Round-robin pointer width; never narrower than one bit.
  function automatic int unsigned ptr_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned PTR_W_DEF = ptr_w(NUM_CORES_DEF);
endpackage

// File: rtl/instruction_fetch_arbiter_rr_first_set.sv
// Finds the first set bit of vec_i at or after start_i, wrapping past N-1 to 0.
module rr_first_set
  import instruction_fetch_arbiter_pkg::*;
#(
  parameter int unsigned N  = NUM_CORES_DEF,
  parameter int unsigned PW = ptr_w(N)
) (
  input  logic [N-1:0]  vec_i,
  input  logic [PW-1:0] start_i,
  output logic          found_o,
  output logic [PW-1:0] idx_o
);
  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  logic [PW:0]    sum;

  always_comb begin
    // Rotate so that start_i lands on bit 0, then take the lowest set bit.
    dbl     = {vec_i, vec_i} >> start_i;
    rot     = dbl[N-1:0];
    found_o = 1'b0;
    sum     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found_o = 1'b1;
        sum     = {1'b0, start_i} + (PW+1)'(k);
      end
    end
    if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
    idx_o = sum[PW-1:0];
  end
endmodule

// File: rtl/instruction_fetch_arbiter.sv
// Two-port round-robin arbiter sharing a dual-read instruction memory among NUM_CORES fetchers.
module instruction_fetch_arbiter
  import instruction_fetch_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CORES     = NUM_CORES_DEF,
  parameter int unsigned ADDR_WIDTH_IM = ADDR_WIDTH_IM_DEF,
  parameter int unsigned INSTR_WIDTH   = INSTR_WIDTH_DEF
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               fetch_enable,
  input  logic [NUM_CORES-1:0]               req,
  input  logic [NUM_CORES*ADDR_WIDTH_IM-1:0] req_addr,
  output logic [NUM_CORES-1:0]               gnt,
  output logic [NUM_CORES-1:0]               rvalid,
  output logic [NUM_CORES*INSTR_WIDTH-1:0]   rdata,
  output logic [ADDR_WIDTH_IM-1:0]           im_address_1,
  output logic [ADDR_WIDTH_IM-1:0]           im_address_2,
  input  logic [INSTR_WIDTH-1:0]             im_read_data_1,
  input  logic [INSTR_WIDTH-1:0]             im_read_data_2
);
  localparam int unsigned PW = ptr_w(NUM_CORES);

  logic [PW-1:0]                             rr_ptr_q, rr_ptr_d;
  logic [NUM_CORES-1:0]                      rvalid_q;
  logic [NUM_CORES-1:0][INSTR_WIDTH-1:0]     rdata_q;
  logic [NUM_CORES-1:0][ADDR_WIDTH_IM-1:0]   addr_a;
  logic [NUM_CORES-1:0]                      elig, elig2;
  logic                                      found1, found2;
  logic [PW-1:0]                             idx1, idx2, last;
  logic [PW:0]                               nxt;

  assign addr_a = req_addr;
  // Holding gnt low during reset keeps it clean even while req is driven.
  assign elig   = (fetch_enable && rst_n) ? req : '0;

  rr_first_set #(.N(NUM_CORES), .PW(PW)) u_first (
    .vec_i(elig), .start_i(rr_ptr_q), .found_o(found1), .idx_o(idx1)
  );

  always_comb begin
    elig2 = elig;
    if (found1) elig2[idx1] = 1'b0;
  end

  // Same start point with the first winner masked yields the next one in scan order.
  rr_first_set #(.N(NUM_CORES), .PW(PW)) u_second (
    .vec_i(elig2), .start_i(rr_ptr_q), .found_o(found2), .idx_o(idx2)
  );

  always_comb begin
    gnt = '0;
    if (found1) gnt[idx1] = 1'b1;
    if (found2) gnt[idx2] = 1'b1;
  end

  assign im_address_1 = found1 ? addr_a[idx1] : '0;
  assign im_address_2 = found2 ? addr_a[idx2] : '0;

  always_comb begin
    last = found2 ? idx2 : idx1;
    nxt  = {1'b0, last} + (PW+1)'(1);
    if (nxt == (PW+1)'(NUM_CORES)) nxt = '0;
    rr_ptr_d = found1 ? nxt[PW-1:0] : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
      rvalid_q <= '0;
      rdata_q  <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      rvalid_q <= gnt;
      if (found1) rdata_q[idx1] <= im_read_data_1;
      if (found2) rdata_q[idx2] <= im_read_data_2;
    end
  end

  assign rvalid = rvalid_q;
  assign rdata  = rdata_q;
endmodule

// File: doc/instruction_fetch_arbiter.md
INSTRUCTION_FETCH_ARBITER -- requirements
Module: instruction_fetch_arbiter

Interface
REQ-001 Parameter NUM_CORES, 4, number of fetch requesters sharing the instruction memory (2..16).
REQ-002 Parameter ADDR_WIDTH_IM, 8, instruction memory address width.
REQ-003 Parameter INSTR_WIDTH, 32, instruction width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 fetch_enable  input  1  global enable; low means no grants issued.
REQ-007 req  input  NUM_CORES  per-core fetch request, level, held until granted.
REQ-008 req_addr  input  NUM_CORES*ADDR_WIDTH_IM  per-core fetch address; slice i belongs to core i; stable while req[i] is high.
REQ-009 gnt  output  NUM_CORES  per-core grant, combinational, same cycle as the accepted request.
REQ-010 rvalid  output  NUM_CORES  per-core read-data valid, registered, one-cycle pulse.
REQ-011 rdata  output  NUM_CORES*INSTR_WIDTH  per-core registered instruction.
REQ-012 im_address_1, im_address_2  output  ADDR_WIDTH_IM each  drive the two memory read ports.
REQ-013 im_read_data_1, im_read_data_2  input  INSTR_WIDTH each  combinational read data from the two memory ports.

Function
REQ-014 Each cycle with fetch_enable high, the arbiter SHALL grant at most two requesters: the first and second asserted req bits found scanning upward (with wrap) from rr_ptr.
REQ-015 The first winner SHALL be served on port 1, the second on port 2; with no second winner, im_address_2 SHALL be 0 and port 2 data ignored.
REQ-016 With no winner on port 1, im_address_1 SHALL be 0.
REQ-017 gnt SHALL be one-hot or two-hot, SHALL be a subset of req, and SHALL be all-zero when fetch_enable is low or req is zero.
REQ-018 At the clock edge ending a grant cycle, rdata slice of each winner SHALL capture its port's read data, and rvalid of that core SHALL be 1 for exactly the next cycle.
REQ-019 Latency: request granted in cycle t yields rvalid and rdata in cycle t+1; non-granted cores' rdata SHALL hold their previous value and rvalid SHALL be 0.
REQ-020 rr_ptr (width clog2(NUM_CORES)) SHALL update after any grant to (index of last winner + 1) mod NUM_CORES; unchanged when nothing is granted.
REQ-021 Wrap-around: scanning past index NUM_CORES-1 SHALL continue at 0; the same core SHALL never win both ports in one cycle.
REQ-022 Fairness: a continuously requesting core SHALL be granted within ceil((NUM_CORES-1)/2)+1 cycles of fetch_enable high.
REQ-023 A core may re-assert req in the cycle after its grant (back-to-back fetch); the arbiter SHALL treat it as a new request.
REQ-024 fetch_enable falling SHALL not suppress rvalid for grants already issued in the previous cycle.
REQ-025 Core i with two identical addresses from two cores SHALL still occupy two ports.

Reset
REQ-026 While rst_n is low: rr_ptr = 0, rvalid = 0, rdata = 0; gnt SHALL be 0 regardless of req.
REQ-027 Reset asserted mid-operation SHALL cancel any pending rvalid; the first grant after reset release SHALL scan from core 0.

Structure
REQ-028 A shared package SHALL hold defaults for ADDR_WIDTH_IM and INSTR_WIDTH and the pointer-width helper constant.
REQ-029 One sub-module rr_first_set (returns first set bit at/after a start index, with found flag) SHALL be instantiated twice: second instance masks the first winner.
REQ-030 The instruction memory SHALL remain outside this block.

Verification
REQ-031 Reset: rst_n low with req=4'b1111 -> gnt=0, rvalid=0, rdata=0; release -> first grant gnt=4'b0011.
REQ-032 Single requester: req=4'b0100, addr=0x10, memory[0x10]=0xDEADBEEF -> gnt=4'b0100, im_address_1=0x10, next cycle rvalid=4'b0100, rdata slice 2=0xDEADBEEF.
REQ-033 Rotation: req=4'b1111 held 4 cycles -> gnt sequence 0011, 1100, 0011, 1100; rvalid follows one cycle later.
REQ-034 Wrap: rr_ptr=3, req=4'b1001 -> port 1 serves core 3, port 2 core 0, rr_ptr becomes 1.
REQ-035 Enable gating: fetch_enable low with req=4'b1111 -> gnt=0, rr_ptr unchanged; drop enable one cycle after a grant -> that rvalid still pulses.
REQ-036 Mid-operation reset: assert rst_n low in cycle after a grant -> rvalid=0 immediately, rdata cleared.
